// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding and
// instruction-register bit positions.
package cpu_sequencer_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC0 = 2'd1;
  localparam logic [1:0] ST_EXEC1 = 2'd2;
  localparam logic [1:0] ST_INTR  = 2'd3;

  localparam int IR_TWO_CYCLE = 7;

  typedef enum logic [1:0] {
    S_FETCH = ST_FETCH,
    S_EXEC0 = ST_EXEC0,
    S_EXEC1 = ST_EXEC1,
    S_INTR  = ST_INTR
  } state_e;

endpackage

// File: rtl/cpu_sequencer_irq_sync.sv
// Multi-flop synchronizer for the asynchronous irq line, followed by a
// rising-edge detector on the synchronized level.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic irq_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign irq_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer: fetch / exec0 / exec1 / interrupt entry, with
// the instruction register, carry flag and interrupt-enable flag.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       dec_m,
  input  logic       dec_wc,
  input  logic       dec_cli,
  input  logic       dec_sti,
  input  logic       alu_carry,
  input  logic       irq,
  output logic [7:0] inst,
  output logic       cycle,
  output logic       carry,
  output logic       ie,
  output logic       pc_inc,
  output logic       exec_en,
  output logic       int_ack,
  output logic       stall,
  output logic [1:0] dbg_state,
  output logic       dbg_pending
);

  state_e     r_state;
  logic [7:0] r_inst;
  logic       r_carry;
  logic       r_ie;
  logic       r_pending;
  logic       r_pc_inc;

  logic w_irq_rise;
  logic w_exec1_wait;
  logic w_exec_en;
  logic w_stall;
  logic w_ie_next;
  logic w_take;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .irq_rise (w_irq_rise)
  );

  // ie_next folds in this cycle's CLI/STI so a CLI in the last execute cycle
  // already blocks interrupt entry at that boundary.
  always_comb begin
    w_exec1_wait = (r_state == S_EXEC1) & dec_m & ~mem_ready;
    w_exec_en    = (r_state == S_EXEC0) | ((r_state == S_EXEC1) & ~w_exec1_wait);
    w_stall      = ((r_state == S_FETCH) & ~mem_ready) | w_exec1_wait;
    w_ie_next    = r_ie;
    if (dec_cli & w_exec_en)      w_ie_next = 1'b0;
    else if (dec_sti & w_exec_en) w_ie_next = 1'b1;
    w_take       = r_pending & w_ie_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_inst    <= 8'h00;
      r_carry   <= 1'b0;
      r_ie      <= 1'b0;
      r_pending <= 1'b0;
      r_pc_inc  <= 1'b0;
    end else begin
      r_pc_inc <= 1'b0;
      r_ie     <= w_ie_next;
      if (dec_wc & w_exec_en) r_carry <= alu_carry;
      // A new edge arriving during INTR must survive the clear.
      if (w_irq_rise)               r_pending <= 1'b1;
      else if (r_state == S_INTR)   r_pending <= 1'b0;

      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_inst   <= mem_rdata;
            r_pc_inc <= 1'b1;
            r_state  <= S_EXEC0;
          end
        end
        S_EXEC0: begin
          if (r_inst[IR_TWO_CYCLE]) r_state <= S_EXEC1;
          else                      r_state <= w_take ? S_INTR : S_FETCH;
        end
        S_EXEC1: begin
          if (!w_exec1_wait) r_state <= w_take ? S_INTR : S_FETCH;
        end
        S_INTR: begin
          r_ie    <= 1'b0;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign inst        = r_inst;
  assign cycle       = (r_state == S_EXEC1);
  assign carry       = r_carry;
  assign ie          = r_ie;
  assign pc_inc      = r_pc_inc;
  assign exec_en     = w_exec_en;
  assign int_ack     = (r_state == S_INTR);
  assign stall       = w_stall;
  assign dbg_state   = r_state;
  assign dbg_pending = r_pending;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the driver pushes the expected per-cycle
// observation into a queue, and a monitor pops and compares it.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_rdata;
  logic       mem_ready, dec_m, dec_wc, dec_cli, dec_sti, alu_carry, irq;
  logic [7:0] inst;
  logic       cycle, carry, ie, pc_inc, exec_en, int_ack, stall;
  logic [1:0] dbg_state;
  logic       dbg_pending;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         chk_tog = 1'b0;

  cpu_sequencer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dec_m(dec_m), .dec_wc(dec_wc), .dec_cli(dec_cli), .dec_sti(dec_sti),
    .alu_carry(alu_carry), .irq(irq), .inst(inst), .cycle(cycle),
    .carry(carry), .ie(ie), .pc_inc(pc_inc), .exec_en(exec_en),
    .int_ack(int_ack), .stall(stall), .dbg_state(dbg_state),
    .dbg_pending(dbg_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] rd, input logic mr, input logic m,
                        input logic wc, input logic cli, input logic sti,
                        input logic ac, input logic irqv);
    mem_rdata = rd; mem_ready = mr; dec_m = m; dec_wc = wc;
    dec_cli = cli; dec_sti = sti; alu_carry = ac; irq = irqv;
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic [7:0] in,
                     input logic cy, input logic ca, input logic ien,
                     input logic pci, input logic ex, input logic ack,
                     input logic stl, input logic pend);
    exp_q.push_back({st, in, cy, ca, ien, pci, ex, ack, stl, pend});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e, o;
    string        n;
    forever begin
      @(negedge clk or chk_tog);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        o = {dbg_state, inst, cycle, carry, ie, pc_inc, exec_en, int_ack, stall, dbg_pending};
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL %s got=%05h exp=%05h (state,inst,cyc,carry,ie,pc_inc,exec_en,int_ack,stall,pending)",
                   n, o, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", ST_FETCH, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);

    // single-cycle instruction
    tick(); rst_n = 1'b1; set_in(8'h05, 1, 0, 0, 0, 0, 0, 0);
    chk("t1_fetch", ST_FETCH, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_exec0", ST_EXEC0, 8'h05, 0, 0, 0, 1, 1, 0, 0, 0);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_back_fetch", ST_FETCH, 8'h05, 0, 0, 0, 0, 0, 0, 1, 0);

    // two-cycle instruction with 3 EXEC1 waits, carry write in EXEC0
    tick(); set_in(8'h85, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_fetch", ST_FETCH, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 1, 1, 0, 0, 1, 0);
    chk("t2_exec0_wc", ST_EXEC0, 8'h85, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); set_in(8'h00, 0, 1, 1, 0, 0, 0, 0);
      chk("t2_exec1_stall", ST_EXEC1, 8'h85, 1, 1, 0, 0, 0, 0, 1, 0);
    end
    tick(); set_in(8'h00, 1, 1, 0, 0, 0, 0, 0);
    chk("t2_exec1_go", ST_EXEC1, 8'h85, 1, 1, 0, 0, 1, 0, 0, 0);

    // enable interrupts, then irq mid-instruction
    tick(); set_in(8'h01, 1, 0, 0, 0, 0, 0, 0);
    chk("t3_fetch_sti", ST_FETCH, 8'h85, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 0, 0, 0, 1, 0, 0);
    chk("t3_exec0_sti", ST_EXEC0, 8'h01, 0, 1, 0, 1, 1, 0, 0, 0);
    tick(); set_in(8'h82, 1, 0, 0, 0, 0, 0, 1);
    chk("t3_fetch_irq", ST_FETCH, 8'h01, 0, 1, 1, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_exec0", ST_EXEC0, 8'h82, 0, 1, 1, 1, 1, 0, 0, 0);
    tick(); set_in(8'h00, 0, 1, 0, 0, 0, 0, 1);
    chk("t3_exec1_stall", ST_EXEC1, 8'h82, 1, 1, 1, 0, 0, 0, 1, 0);
    tick(); set_in(8'h00, 1, 1, 0, 0, 0, 0, 1);
    chk("t3_exec1_pend", ST_EXEC1, 8'h82, 1, 1, 1, 0, 1, 0, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_intr", ST_INTR, 8'h82, 0, 1, 1, 0, 0, 1, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_after_intr", ST_FETCH, 8'h82, 0, 1, 0, 0, 0, 0, 1, 0);

    // CLI in final cycle blocks entry; later STI takes it
    tick(); set_in(8'h01, 1, 0, 0, 0, 0, 0, 0);
    chk("t4_fetch_sti", ST_FETCH, 8'h82, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_exec0_sti", ST_EXEC0, 8'h01, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 1);
      chk("t4_fetch_wait", ST_FETCH, 8'h01, 0, 1, 1, 0, 0, 0, 1, 0);
    end
    tick(); set_in(8'h03, 1, 0, 0, 0, 0, 0, 1);
    chk("t4_fetch_cli", ST_FETCH, 8'h01, 0, 1, 1, 0, 0, 0, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 1, 0, 0, 1);
    chk("t4_exec0_cli", ST_EXEC0, 8'h03, 0, 1, 1, 1, 1, 0, 0, 1);
    tick(); set_in(8'h04, 1, 0, 0, 0, 0, 0, 1);
    chk("t4_no_intr", ST_FETCH, 8'h03, 0, 1, 0, 0, 0, 0, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 0, 1, 0, 1);
    chk("t4_exec0_sti2", ST_EXEC0, 8'h04, 0, 1, 0, 1, 1, 0, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_intr", ST_INTR, 8'h04, 0, 1, 1, 0, 0, 1, 0, 1);
    tick(); set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_after_intr", ST_FETCH, 8'h04, 0, 1, 0, 0, 0, 0, 1, 0);

    // asynchronous reset during an EXEC1 stall
    tick(); set_in(8'h90, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_fetch", ST_FETCH, 8'h04, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(); set_in(8'h00, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_exec0", ST_EXEC0, 8'h90, 0, 1, 0, 1, 1, 0, 0, 0);
    tick(); set_in(8'h00, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_exec1_stall", ST_EXEC1, 8'h90, 1, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", ST_FETCH, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    chk_tog = ~chk_tog;
    tick();
    chk("t5_reset_hold", ST_FETCH, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); rst_n = 1'b1; set_in(8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_released", ST_FETCH, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);

    tick(); tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got=%0d unchecked exp=0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle sequencer for the CPU core. Holds the instruction register, carry flag and interrupt-enable flag. Steps each instruction through fetch, cycle 0 and optional cycle 1, and generates the `cycle` and `carry` inputs consumed by the combinational control decoder. Also inserts interrupt-entry cycles at instruction boundaries and stalls on memory wait states.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the `irq` synchronizer (legal range ≥2).
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mem_rdata`  in  8: instruction byte from the memory bus.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `dec_m`  in  1: decoder M (memory access in cycle 1).
- `dec_wc`  in  1: decoder WC (write carry this cycle).
- `dec_cli`  in  1: decoder CLI (clear interrupt enable).
- `dec_sti`  in  1: set interrupt enable (return-from-interrupt path).
- `alu_carry`  in  1: ALU carry-out.
- `irq`  in  1: asynchronous level interrupt request.
- `inst`  out  8: instruction register, to the decoder.
- `cycle`  out  1: 0 in EXEC0, 1 in EXEC1.
- `carry`  out  1: carry flag.
- `ie`  out  1: interrupt-enable flag.
- `pc_inc`  out  1: advance PC (one-cycle pulse).
- `exec_en`  out  1: decoder strobes are valid and may commit this cycle.
- `int_ack`  out  1: interrupt-entry pulse; PC loads the vector and ISP is selected.
- `stall`  out  1: waiting on `mem_ready`.

## Operation
- States: FETCH, EXEC0, EXEC1, INTR. Encoding is 2-bit binary, held in the shared header.
- FETCH:
  - Drive `stall = ~mem_ready`.
  - When `mem_ready`: `inst <= mem_rdata`, pulse `pc_inc`, go to EXEC0.
- EXEC0:
  - `cycle = 0`, `exec_en = 1`.
  - If `inst[7]`: go to EXEC1.
  - Otherwise, at the instruction boundary: go to INTR if `take`, else FETCH.
- EXEC1:
  - `cycle = 1`.
  - If `dec_m & ~mem_ready`: hold, `stall = 1`, `exec_en = 0`.
  - Otherwise: `exec_en = 1`, then boundary → INTR if `take`, else FETCH.
- INTR: `int_ack = 1` for exactly one cycle, `ie <= 0`, `pending <= 0`, then go to FETCH.
- `take = pending & ie_next`.
  - `ie_next` is the value `ie` will hold after the current cycle's CLI/STI update.
  - Consequence: a CLI in the final execute cycle blocks entry.
- Carry: `carry <= alu_carry` only when `dec_wc & exec_en`. Otherwise hold.
- Interrupt enable:
  - `ie <= 0` when `dec_cli & exec_en`.
  - `ie <= 1` when `dec_sti & exec_en`.
  - CLI wins if both are asserted.
- IRQ path:
  - `irq` passes through `SYNC_STAGES` flops.
  - A rising edge of the synchronized signal sets `pending`.
  - `pending` stays set until INTR. It is not cleared by `ie = 0`.
  - A new edge arriving in INTR is not lost: set takes priority over clear.

## Timing
- Reset values:
  - state = FETCH.
  - `inst = 8'h00`, `carry = 0`, `ie = 0`, `pending = 0`, synchronizer flops = 0.
  - Outputs: `cycle = 0`, `exec_en = 0`, `pc_inc = 0`, `int_ack = 0`, `stall = 0`.
  - `stall` may rise combinationally in FETCH.
- Reset mid-instruction aborts immediately. No partial commit of carry or ie.
- Instruction latency with zero wait states:
  - single-cycle instruction (`inst[7] = 0`): 2 clocks (FETCH, EXEC0);
  - `inst[7] = 1`: 3 clocks.
- Each FETCH/EXEC1 wait cycle adds one clock. Outputs are stable while stalled.
- IRQ latency from `irq` rise to `pending`: `SYNC_STAGES + 1` clocks.
- Interrupt entry happens only at an instruction boundary and adds 1 clock (INTR).
- `pc_inc` and `int_ack` are never asserted in the same cycle.
- `exec_en` is never asserted in FETCH or INTR.

## Structure
- Shared header (`` `include ``) holds:
  - the state localparams `ST_FETCH = 2'd0`, `ST_EXEC0 = 2'd1`, `ST_EXEC1 = 2'd2`, `ST_INTR = 2'd3`;
  - the bit index `IR_TWO_CYCLE = 7`.
- One sub-module, `irq_sync`: parameterized synchronizer plus rising-edge detector, output `irq_rise`.
- All other logic lives in the top module, with a single next-state `always` block. Out-of-range state recovers to FETCH.

## Test plan
- Reset, then fetch `8'h05` with `mem_ready = 1`:
  - `inst = 8'h05` at clock 1, `cycle = 0`, `exec_en = 1` at clock 1;
  - FETCH at clock 2, exactly one `pc_inc`.
- Fetch `8'h85` with `dec_m = 1` and `mem_ready` low for 3 cycles in EXEC1:
  - `stall = 1` for 3 cycles, `cycle = 1` throughout;
  - `exec_en` pulses once; total 6 clocks.
- Pulse `dec_wc` with `alu_carry = 1` in EXEC0:
  - `carry = 1` next clock;
  - `dec_wc` during an EXEC1 stall leaves `carry` unchanged.
- `ie = 1`, raise `irq` mid-instruction:
  - INTR follows the boundary, `int_ack` asserted one cycle, `ie = 0`, `pending = 0`;
  - next state is FETCH.
- `ie = 1`, `pending` set, `dec_cli` in the final EXEC0:
  - no INTR, `pending` stays 1;
  - a later `dec_sti` instruction enters INTR at its boundary.
- Assert `rst_n = 0` during EXEC1 stall: all outputs and state return to reset values asynchronously, before the next clock edge.
